ext_mem_host: RTL

Host-side initiator for the CPU's external memory ports (instruction-memory ext port and data-memory ext port).
- Streams a program image into instruction memory while holding the CPU in reset.
- Releases reset, asserts enable for a programmed number of cycles, then reads a window of data memory out through a valid/ready stream.
- Sits between the testbench or debug transport and the cpu top.

---
 rtl/ext_mem_host.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ext_mem_host.sv
// Purpose : host-side initiator that loads the CPU instruction memory, runs the CPU
//           for a set number of cycles, then streams a window of data memory out.
// Latency : program words are written in their handshake cycle; one dump word per 3 cycles at best.
// Backpr. : prog_ready is high only in LOAD; dump_data/dump_last stay stable while dump_valid & !dump_ready.
// Ports   : clk/rst (sync, active-high); start + run_cycles/dump_base/dump_count launch a session;
//           prog_* is the program stream in; *_ext drive the imem ext port, *_ext_2 the dmem ext port;
//           cpu_arst_n/cpu_enable control the CPU; dump_* is the dump stream out;
//           busy/done/load_ovf/verify_err report status.
// Option  : define LOADER_READBACK_EN to add the VERIFY read-back pass after LOAD.
module ext_mem_host #(
   parameter int DATA_W     = 32,
   parameter int IMEM_DEPTH = 512,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       run_cycles,
   input  logic [31:0]       dump_base,
   input  logic [10:0]       dump_count,
   input  logic              prog_valid,
   output logic              prog_ready,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_last,
   output logic [31:0]       addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [DATA_W-1:0] wdata_ext,
   input  logic [DATA_W-1:0] rdata_ext,
   output logic [31:0]       addr_ext_2,
   output logic              wen_ext_2,
   output logic              ren_ext_2,
   output logic [DATA_W-1:0] wdata_ext_2,
   input  logic [DATA_W-1:0] rdata_ext_2,
   output logic              cpu_arst_n,
   output logic              cpu_enable,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic              busy,
   output logic              done,
   output logic              load_ovf,
   output logic              verify_err
);

   localparam int KW = $clog2(IMEM_DEPTH + 1);

   // S_VERIFY is only ever entered when the read-back option is built in.
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_VERIFY, S_RUN, S_DUMP_RD, S_DUMP_CAP, S_DUMP_OUT, S_DONE
   } state_t;

   state_t            state;
   logic [KW-1:0]     k;          // words loaded so far
   logic [10:0]       j;          // dump word index
   logic [31:0]       cyc;        // enable cycles elapsed in RUN
   logic [31:0]       run_q;
   logic [31:0]       base_q;
   logic [10:0]       cnt_q;
   logic [DATA_W-1:0] hold;
   logic              load_ovf_q;

   logic   prog_hs;
   logic   last_word;
   logic   dump_last_w;
   state_t dump_entry;
   state_t run_entry;

   assign prog_hs     = (state == S_LOAD) && prog_valid;
   assign last_word   = prog_last || (k == KW'(IMEM_DEPTH - 1));
   assign dump_last_w = (j == cnt_q - 11'd1);
   // Zero-length phases are skipped entirely rather than spending a cycle in them.
   assign dump_entry  = (cnt_q == 11'd0) ? S_DONE : S_DUMP_RD;
   assign run_entry   = (run_q == 32'd0) ? dump_entry : S_RUN;

`ifdef LOADER_READBACK_EN
   logic [KW-1:0]     v;          // read-back address index
   logic              rd_pend;    // a read issued last cycle returns data now
   logic [DATA_W-1:0] xor_ld;
   logic [DATA_W-1:0] xor_rb;
   logic              verify_err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         k          <= '0;
         j          <= '0;
         cyc        <= '0;
         run_q      <= '0;
         base_q     <= '0;
         cnt_q      <= '0;
         hold       <= '0;
         load_ovf_q <= 1'b0;
`ifdef LOADER_READBACK_EN
         v            <= '0;
         rd_pend      <= 1'b0;
         xor_ld       <= '0;
         xor_rb       <= '0;
         verify_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  run_q      <= run_cycles;
                  base_q     <= dump_base;
                  cnt_q      <= dump_count;
                  load_ovf_q <= 1'b0;
                  k          <= '0;
                  j          <= '0;
                  cyc        <= '0;
`ifdef LOADER_READBACK_EN
                  v            <= '0;
                  rd_pend      <= 1'b0;
                  xor_ld       <= '0;
                  xor_rb       <= '0;
                  verify_err_q <= 1'b0;
`endif
                  state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (prog_valid) begin
                  k <= k + KW'(1);
`ifdef LOADER_READBACK_EN
                  xor_ld <= xor_ld ^ prog_data;
`endif
                  if (last_word) begin
                     if (!prog_last) load_ovf_q <= 1'b1;
`ifdef LOADER_READBACK_EN
                     state <= S_VERIFY;
`else
                     state <= run_entry;
`endif
                  end
               end
            end
`ifdef LOADER_READBACK_EN
            S_VERIFY: begin
               // Reads are issued for v = 0..k-1; the final compare waits for the last return.
               rd_pend <= (v != k);
               if (v != k) v <= v + KW'(1);
               if (rd_pend) xor_rb <= xor_rb ^ rdata_ext;
               if ((v == k) && !rd_pend) begin
                  if (xor_rb != xor_ld) verify_err_q <= 1'b1;
                  state <= run_entry;
               end
            end
`endif
            S_RUN: begin
               if (cyc == run_q - 32'd1) state <= dump_entry;
               else                      cyc   <= cyc + 32'd1;
            end
            S_DUMP_RD:  state <= S_DUMP_CAP;
            S_DUMP_CAP: begin
               hold  <= rdata_ext_2;
               state <= S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
               if (dump_ready) begin
                  if (dump_last_w) state <= S_DONE;
                  else begin
                     j     <= j + 11'd1;
                     state <= S_DUMP_RD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign prog_ready  = (state == S_LOAD);
   assign wen_ext     = prog_hs;
   assign wdata_ext   = prog_hs ? prog_data : '0;
   assign ren_ext_2   = (state == S_DUMP_RD);
   assign addr_ext_2  = (state == S_DUMP_RD) ? base_q + (32'(j) << 2) : 32'd0;
   assign wen_ext_2   = 1'b0;
   assign wdata_ext_2 = '0;
   // CPU stays out of reset from RUN through DONE so its state can be inspected.
   assign cpu_arst_n  = (state == S_RUN) || (state == S_DUMP_RD) || (state == S_DUMP_CAP) ||
                        (state == S_DUMP_OUT) || (state == S_DONE);
   assign cpu_enable  = (state == S_RUN);
   assign dump_valid  = (state == S_DUMP_OUT);
   assign dump_data   = hold;
   assign dump_last   = (state == S_DUMP_OUT) && dump_last_w;
   assign busy        = (state != S_IDLE) && (state != S_DONE);
   assign done        = (state == S_DONE);
   assign load_ovf    = load_ovf_q;

`ifdef LOADER_READBACK_EN
   assign ren_ext    = (state == S_VERIFY) && (v != k);
   assign addr_ext   = (state == S_LOAD)   ? (32'(k) << 2) :
                       (state == S_VERIFY) ? (32'(v) << 2) : 32'd0;
   assign verify_err = verify_err_q;
`else
   assign ren_ext    = 1'b0;
   assign addr_ext   = (state == S_LOAD) ? (32'(k) << 2) : 32'd0;
   assign verify_err = 1'b0;
`endif

   // Data memory depth is not used for range checking: the SRAM wraps addresses itself.
   logic unused_ok;
   assign unused_ok = ^{1'b0, rdata_ext, (DMEM_DEPTH > 0)};

endmodule
